instr_issue_arbiter: RTL and testbench
======================================

// Module: instr_issue_arbiter
// PURPOSE
//  Round-robin scheduler that shares the single CPU instruction port among NREQ instruction sources
//  (random generators, directed streams). Issues one instruction at a time and waits a fixed number
//  of cycles for the CPU result. Returns the result tagged with the requester id, and drives NOP
//  whenever no instruction is being issued. Sits between the stimulus sources and the CPU instr/result pins.
// PARAMETERS
//  NREQ        4             number of requesters, 2..16
//  XLEN        32            instruction/result width
//  WAIT_CYCLES 1             clock edges from issue edge to result-sample edge, >=1
//  NOP_INSTR   32'h0000_0013 value driven on cpu_instr when idle (addi x0,x0,0)
// PORTS
//  clk         in   1             clock, rising edge
//  rst         in   1             asynchronous reset, active-low
//  en          in   1             1 = new grants allowed; 0 = finish in-flight op, then hold
//  req         in   NREQ          per-requester request, held until its gnt
//  req_instr   in   NREQ*XLEN     instr of requester i in bits [i*XLEN +: XLEN], stable while req[i]
//  gnt         out  NREQ          one-hot 1-cycle pulse: instr of that requester accepted
//  cpu_instr   out  XLEN          instruction to CPU
//  cpu_issue   out  1             1-cycle pulse, cpu_instr is a real instruction this cycle
//  cpu_result  in   XLEN          CPU result bus
//  rsp_valid   out  1             1-cycle pulse, rsp_id/rsp_result valid
//  rsp_id      out  $clog2(NREQ)  requester that owns rsp_result
//  rsp_result  out  XLEN          captured cpu_result
//  busy        out  1             1 while an instruction is in flight (state != IDLE)
//  issue_count out  32            number of instructions issued, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, gnt=0, cpu_instr=NOP_INSTR, cpu_issue=0, rsp_valid=0,
//   rsp_id=0, rsp_result=0, busy=0, issue_count=0, rr_ptr=NREQ-1 (requester 0 has first priority).
//   Reset mid-operation drops the in-flight instruction; no rsp is produced for it.
//  All outputs are registered. FSM states: IDLE, WAIT.
//  IDLE, edge with en=1 and |req:
//   - Winner is the first set req[i] searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
//   - Registers cpu_instr<=req_instr[winner], cpu_issue<=1, gnt<=onehot(winner).
//   - Registers id<=winner, rr_ptr<=winner, cnt<=WAIT_CYCLES, issue_count++, state<=WAIT.
//  IDLE, otherwise: outputs hold idle values (cpu_instr=NOP_INSTR, gnt=0, cpu_issue=0).
//  WAIT, every edge:
//   - cpu_instr<=NOP_INSTR, cpu_issue<=0, gnt<=0.
//   - If cnt==1: rsp_valid<=1, rsp_result<=cpu_result, rsp_id<=id, state<=IDLE.
//   - Else: cnt--.
//  rsp_valid is forced 0 on every edge that does not set it (1-cycle pulse).
//  Timing: grant at edge E0. gnt/cpu_issue are high in cycle E0..E1. cpu_result is sampled at edge
//   E0+WAIT_CYCLES. rsp_valid is high for one cycle after that edge.
//   Next grant no earlier than edge E0+WAIT_CYCLES+1, so throughput is 1 instr per WAIT_CYCLES+1 cycles.
//  req sampled only in IDLE. A req dropped before grant is ignored with no error.
//   A requester may re-assert in the cycle after its gnt.
//  en=0 during WAIT: the in-flight op completes and its rsp is still produced; no new grant follows.
//  busy = (state==WAIT). gnt is never asserted for a requester whose req was 0 at the grant edge.
// TESTING
//  1 reset: rst=0 mid-WAIT -> next cycle cpu_instr=32'h13, gnt=0, busy=0, issue_count=0, no rsp_valid.
//  2 single: req=4'b0100, req_instr[2]=32'h00500093, WAIT_CYCLES=1 -> gnt=4'b0100 and cpu_issue for 1
//    cycle with cpu_instr=32'h00500093; cpu_result=5 -> rsp_valid, rsp_id=2, rsp_result=5 one cycle later.
//  3 round-robin: req=4'b1111 held -> grant order 0,1,2,3,0; grants exactly 2 cycles apart (WAIT_CYCLES=1).
//  4 fairness: req=4'b1001 held -> grants alternate 0,3,0,3; requesters 1 and 2 never granted.
//  5 en gating: en=0 while busy -> rsp still produced, then no gnt while en=0;
//    en=1 -> grant on the next edge.
//  6 counter wrap: preload issue_count to 32'hFFFF_FFFF via 2^32-1 issues (or force) -> one more issue gives 0.

Source files
------------

// File: rtl/instr_issue_arbiter.sv
// instr_issue_arbiter: round-robin issue of NREQ instruction sources onto one CPU instruction port.
//   clk, rst (async, active-low)
//   en                  : allow new grants; an in-flight op always completes
//   req / req_instr     : per-requester request and instruction (requester i at [i*XLEN +: XLEN])
//   gnt                 : one-hot pulse, instruction of that requester accepted
//   cpu_instr/cpu_issue : instruction to CPU (NOP_INSTR when idle) and its issue pulse
//   cpu_result          : CPU result, sampled WAIT_CYCLES edges after the issue edge
//   rsp_valid/rsp_id/rsp_result : tagged result pulse
//   busy, issue_count   : op in flight, wrapping count of issued instructions
module instr_issue_arbiter #(
    parameter int              NREQ        = 4,
    parameter int              XLEN        = 32,
    parameter int              WAIT_CYCLES = 1,
    parameter logic [XLEN-1:0] NOP_INSTR   = XLEN'(32'h0000_0013)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*XLEN-1:0]     req_instr,
    output logic [NREQ-1:0]          gnt,
    output logic [XLEN-1:0]          cpu_instr,
    output logic                     cpu_issue,
    input  logic [XLEN-1:0]          cpu_result,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [XLEN-1:0]          rsp_result,
    output logic                     busy,
    output logic [31:0]              issue_count
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WAIT_CYCLES + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state, state_d;
    logic [IDW-1:0]  rr_ptr, id, win_id, idx;
    logic [IDW:0]    sum;
    logic [CW-1:0]   cnt;
    logic            win_found, grant;
    logic [XLEN-1:0] instr_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign instr_arr[g] = req_instr[g*XLEN +: XLEN];
    end

    // Scan from the farthest candidate to the nearest so the nearest set
    // request after rr_ptr is the last one written and therefore wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        sum       = '0;
        idx       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            sum = (sum >= (IDW+1)'(NREQ)) ? sum - (IDW+1)'(NREQ) : sum;
            idx = IDW'(sum);
            if (req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
        grant   = (state == IDLE) && en && win_found;
        state_d = grant ? WAIT : (state == WAIT && cnt == CW'(1)) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt         <= '0;
            cpu_instr   <= NOP_INSTR;
            cpu_issue   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            busy        <= 1'b0;
            issue_count <= '0;
            rr_ptr      <= IDW'(NREQ - 1);
            id          <= '0;
            cnt         <= '0;
        end else begin
            gnt       <= '0;
            cpu_instr <= NOP_INSTR;
            cpu_issue <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= (state_d == WAIT);
            if (grant) begin
                gnt         <= NREQ'(1) << win_id;
                cpu_instr   <= instr_arr[win_id];
                cpu_issue   <= 1'b1;
                id          <= win_id;
                rr_ptr      <= win_id;
                cnt         <= CW'(WAIT_CYCLES);
                issue_count <= issue_count + 32'd1;
            end
            if (state == WAIT) begin
                if (cnt == CW'(1)) begin
                    rsp_valid  <= 1'b1;
                    rsp_result <= cpu_result;
                    rsp_id     <= id;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_issue_arbiter.sv
// tb_instr_issue_arbiter: directed and randomized checks of instr_issue_arbiter against a behavioural model.
module tb_instr_issue_arbiter;
    localparam int          NREQ = 4;
    localparam int          WC   = 1;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 0, rst = 0, en = 0;
    logic [3:0]  req = '0;
    logic [31:0] instr [NREQ];
    logic [127:0] req_instr;
    logic [31:0] cpu_result = '0;
    logic [3:0]  gnt;
    logic [31:0] cpu_instr, rsp_result, issue_count;
    logic        cpu_issue, rsp_valid, busy;
    logic [1:0]  rsp_id;

    assign req_instr = {instr[3], instr[2], instr[1], instr[0]};

    instr_issue_arbiter #(.NREQ(NREQ), .XLEN(32), .WAIT_CYCLES(WC), .NOP_INSTR(NOP)) u_dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .req_instr(req_instr), .gnt(gnt),
        .cpu_instr(cpu_instr), .cpu_issue(cpu_issue), .cpu_result(cpu_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .busy(busy), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    bit chk_on = 0, preload = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int oh2id(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Model: remaining wait edges of the op in flight, its owner, the last
    // winner for the rotating search, and the expected registered outputs.
    int          m_left = 0, m_id = 0, m_last = NREQ - 1;
    logic [31:0] m_count = '0;
    logic [3:0]  e_gnt = '0;
    logic [31:0] e_instr = NOP, e_rres = '0;
    logic        e_issue = 0, e_rv = 0, e_busy = 0;
    logic [1:0]  e_rid = '0;

    always @(posedge clk or negedge rst) begin : model
        int w;
        bit f;
        if (!rst) begin
            m_left <= 0; m_id <= 0; m_last <= NREQ - 1; m_count <= '0;
            e_gnt <= '0; e_instr <= NOP; e_issue <= 0; e_rv <= 0; e_rid <= '0; e_rres <= '0; e_busy <= 0;
        end else begin
            w = 0;
            f = 0;
            for (int k = 1; k <= NREQ; k++)
                if (!f && req[(m_last + k) % NREQ]) begin
                    f = 1;
                    w = (m_last + k) % NREQ;
                end
            e_gnt <= '0; e_instr <= NOP; e_issue <= 0; e_rv <= 0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                e_busy <= (m_left > 1);
                if (m_left == 1) begin
                    e_rv <= 1; e_rid <= 2'(m_id); e_rres <= cpu_result;
                end
            end else if (en && f) begin
                e_gnt <= 4'(1) << w; e_instr <= instr[w]; e_issue <= 1;
                m_id <= w; m_last <= w; m_left <= WC; e_busy <= 1;
            end
            m_count <= preload ? 32'hFFFF_FFFF : m_count + ((m_left == 0 && en && f) ? 32'd1 : 32'd0);
        end
    end

    always @(negedge clk) if (chk_on) begin
        chk("m_gnt", 32'(gnt), 32'(e_gnt));
        chk("m_cpu_instr", cpu_instr, e_instr);
        chk("m_cpu_issue", 32'(cpu_issue), 32'(e_issue));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("m_rsp_id", 32'(rsp_id), 32'(e_rid));
        chk("m_rsp_result", rsp_result, e_rres);
        chk("m_busy", 32'(busy), 32'(e_busy));
        chk("m_issue_count", issue_count, m_count);
    end

    initial begin
        int ids[$], cyc[$];
        bit bad;
        for (int i = 0; i < NREQ; i++) instr[i] = '0;
        repeat (2) @(negedge clk);
        chk_on = 1;
        chk("rst_cpu_instr", cpu_instr, 32'h13);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_issue_count", issue_count, 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        rst = 1;
        @(negedge clk);
        en = 1; req = 4'b0100; instr[2] = 32'h0050_0093; cpu_result = 32'd5;
        @(negedge clk);
        chk("single_gnt", 32'(gnt), 32'b0100);
        chk("single_issue", 32'(cpu_issue), 1);
        chk("single_instr", cpu_instr, 32'h0050_0093);
        req = '0;
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid), 1);
        chk("single_rsp_id", 32'(rsp_id), 2);
        chk("single_rsp_result", rsp_result, 5);
        chk("single_idle_instr", cpu_instr, 32'h13);
        @(negedge clk);
        chk("single_rsp_pulse", 32'(rsp_valid), 0);
        chk("single_count", issue_count, 1);
        req = 4'b0001; instr[0] = 32'h0010_0093;
        @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 1);
        req = '0;
        #2 rst = 0;
        #1;
        chk("midrst_cpu_instr", cpu_instr, 32'h13);
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_count", issue_count, 0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("midrst_no_rsp", 32'(rsp_valid), 0);
        rst = 1;
        for (int i = 0; i < NREQ; i++) instr[i] = 32'h1000_0000 + i;
        req = 4'hF;
        for (int c = 1; c <= 12 && ids.size() < 5; c++) begin
            @(negedge clk);
            if (gnt != 0) begin ids.push_back(oh2id(gnt)); cyc.push_back(c); end
        end
        req = '0;
        chk("rr_grants", ids.size(), 5);
        for (int n = 0; n < ids.size(); n++) chk("rr_order", ids[n], n % NREQ);
        for (int n = 1; n < cyc.size(); n++) chk("rr_gap", cyc[n] - cyc[n-1], WC + 1);
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1; req = 4'b1001; ids.delete(); bad = 0;
        for (int c = 1; c <= 12 && ids.size() < 4; c++) begin
            @(negedge clk);
            if (gnt[1] | gnt[2]) bad = 1;
            if (gnt != 0) ids.push_back(oh2id(gnt));
        end
        req = '0;
        chk("fair_grants", ids.size(), 4);
        for (int n = 0; n < ids.size(); n++) chk("fair_order", ids[n], (n % 2) ? 3 : 0);
        chk("fair_no_1_2", 32'(bad), 0);
        repeat (3) @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        chk("en_gnt", 32'(gnt), 32'b0010);
        en = 0; req = 4'b0100; instr[2] = 32'hCAFE_0013;
        @(negedge clk);
        chk("en_rsp_valid", 32'(rsp_valid), 1);
        chk("en_rsp_id", 32'(rsp_id), 1);
        repeat (4) begin
            @(negedge clk);
            chk("en_hold_gnt", 32'(gnt), 0);
            chk("en_hold_busy", 32'(busy), 0);
        end
        en = 1;
        @(negedge clk);
        chk("en_resume_gnt", 32'(gnt), 32'b0100);
        chk("en_resume_instr", cpu_instr, 32'hCAFE_0013);
        req = '0;
        repeat (2) @(negedge clk);
        en = 0;
        @(negedge clk);
        #2 force u_dut.issue_count = 32'hFFFF_FFFF;
        preload = 1;
        @(negedge clk);
        chk("wrap_preload", issue_count, 32'hFFFF_FFFF);
        #2 release u_dut.issue_count;
        preload = 0; req = 4'b0001; en = 1;
        @(negedge clk);
        chk("wrap_count", issue_count, 0);
        chk("wrap_gnt", 32'(gnt), 32'b0001);
        req = '0;
        repeat (2) @(negedge clk);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) != 0);
            en = ($urandom_range(0, 9) != 0);
            cpu_result = $urandom;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (gnt[i]) begin
                        req[i] = 1'($urandom_range(0, 1));
                        instr[i] = $urandom;
                    end else if ($urandom_range(0, 19) == 0) req[i] = 0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1;
                    instr[i] = $urandom;
                end
            end
        end
        rst = 1; req = '0;
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
